// File: rtl/xor_stream_parity_pkg.sv
// -----------------------------------------------------------------------------
// xor_pkg
//   Shared types and helpers for the xor_stream_parity block.
//
//   state_t    : frame FSM states (ACCUM = collecting words, HOLD = result held)
//   PAR_EVEN   : parity mode selector value for even parity (out_par = ^col)
//   PAR_ODD    : parity mode selector value for odd parity  (out_par = ~^col)
//   cnt_width  : bits needed to hold a word count in the range 0..max
// -----------------------------------------------------------------------------
package xor_pkg;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   function automatic int cnt_width(input int max);
      return $clog2(max + 1);
   endfunction

endpackage

// File: rtl/xor_word_acc.sv
// -----------------------------------------------------------------------------
// xor_word_acc
//   WIDTH-bit running XOR accumulator.
//
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset, clears the accumulator
//   i_clr    : clear the accumulator at the next edge (frame boundary)
//   i_en     : fold i_data into the accumulator at the next edge
//   i_data   : word to fold in
//   o_acc    : current accumulator contents
//   o_next   : combinational o_acc ^ i_data, used by the parent to capture
//              the final column parity in the same edge that clears o_acc
// -----------------------------------------------------------------------------
module xor_word_acc #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_acc,
   output logic [WIDTH-1:0] o_next
);

   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] w_next;

   assign w_next = r_acc ^ i_data;

   // Clear has priority over enable so a final word never leaks into the
   // following frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc <= '0;
      end else if (i_clr) begin
         r_acc <= '0;
      end else if (i_en) begin
         r_acc <= w_next;
      end
   end

   assign o_acc  = r_acc;
   assign o_next = w_next;

endmodule

// File: rtl/xor_stream_parity.sv
// -----------------------------------------------------------------------------
// xor_stream_parity
//   Accumulates the bitwise XOR of a frame of WIDTH-bit words received over a
//   valid/ready stream and, at end of frame, presents the column parity, a
//   reduced parity bit, a saturating word count and an overflow flag through a
//   one-deep output holding register with its own valid/ready handshake.
//
//   Parameters
//     WIDTH       : data word width (>= 1)
//     MAX_WORDS   : largest legal frame length; longer frames set out_err
//     ODD_PARITY  : 0 = even (out_par = ^out_col), 1 = odd (out_par = ~^out_col)
//
//   Ports
//     clk        : rising-edge clock
//     rst        : synchronous active-high reset; discards any partial frame
//                  and any held result
//     in_valid   : input word present
//     in_ready   : block can accept a word (decoded from state only)
//     in_data    : input word
//     in_last    : in_data is the final word of the frame
//     out_valid  : frame result held in the output register
//     out_ready  : consumer takes the held result
//     out_col    : XOR of all words in the frame
//     out_par    : reduced parity of out_col per ODD_PARITY
//     out_count  : words in frame, saturating at MAX_WORDS
//     out_err    : frame contained more than MAX_WORDS words
// -----------------------------------------------------------------------------
module xor_stream_parity
   import xor_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int MAX_WORDS  = 16,
   parameter int ODD_PARITY = 0
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [WIDTH-1:0]                  in_data,
   input  logic                              in_last,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [WIDTH-1:0]                  out_col,
   output logic                              out_par,
   output logic [cnt_width(MAX_WORDS)-1:0]   out_count,
   output logic                              out_err
);

   localparam int   CW       = cnt_width(MAX_WORDS);
   localparam logic PAR_MODE = (ODD_PARITY != 0) ? PAR_ODD : PAR_EVEN;
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WORDS);

   // ---------------------------------------------------------------- FSM
   state_t r_state;
   state_t w_state_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ACCUM;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // in_ready and out_valid are pure state decodes; the input handshake never
   // looks at in_valid to decide readiness.
   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         ACCUM: begin
            in_ready = 1'b1;
            if (in_valid && in_last) begin
               w_state_nxt = HOLD;
            end
         end
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_state_nxt = ACCUM;
            end
         end
         default: begin
            w_state_nxt = ACCUM;
         end
      endcase
   end

   // --------------------------------------------------------- handshakes
   logic w_accept;
   logic w_accept_mid;
   logic w_accept_last;

   assign w_accept      = in_valid & in_ready;
   assign w_accept_mid  = w_accept & ~in_last;
   assign w_accept_last = w_accept &  in_last;

   // ------------------------------------------------------- accumulator
   logic [WIDTH-1:0] w_acc;
   logic [WIDTH-1:0] w_acc_nxt;

   xor_word_acc #(
      .WIDTH (WIDTH)
   ) u_acc (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_accept_last),
      .i_en   (w_accept_mid),
      .i_data (in_data),
      .o_acc  (w_acc),
      .o_next (w_acc_nxt)
   );

   // ----------------------------------------------- word counter / error
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_inc;
   logic          w_cnt_full;
   logic          r_err_acc;

   // Counter already at MAX_WORDS means the word being accepted now is one
   // beyond the legal length: it flags overflow and leaves the count pinned.
   assign w_cnt_full = (r_cnt == CNT_MAX);
   assign w_cnt_inc  = w_cnt_full ? r_cnt : (r_cnt + 1'b1);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt     <= '0;
         r_err_acc <= 1'b0;
      end else if (w_accept_last) begin
         r_cnt     <= '0;
         r_err_acc <= 1'b0;
      end else if (w_accept_mid) begin
         r_cnt     <= w_cnt_inc;
         r_err_acc <= r_err_acc | w_cnt_full;
      end
   end

   // --------------------------------------------------- output register
   logic [WIDTH-1:0] r_out_col;
   logic             r_out_par;
   logic [CW-1:0]    r_out_count;
   logic             r_out_err;

   // Loaded only on the final word of a frame; the FSM cannot be in HOLD at
   // that point, so a held result is never overwritten. Values persist after
   // handoff and are qualified by out_valid alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_col   <= '0;
         r_out_par   <= PAR_MODE;
         r_out_count <= '0;
         r_out_err   <= 1'b0;
      end else if (w_accept_last) begin
         r_out_col   <= w_acc_nxt;
         r_out_par   <= (^w_acc_nxt) ^ PAR_MODE;
         r_out_count <= w_cnt_inc;
         r_out_err   <= r_err_acc | w_cnt_full;
      end
   end

   assign out_col   = r_out_col;
   assign out_par   = r_out_par;
   assign out_count = r_out_count;
   assign out_err   = r_out_err;

endmodule

// File: tb/tb_xor_stream_parity.sv
// -----------------------------------------------------------------------------
// tb_xor_stream_parity
//   Self-checking bench for xor_stream_parity (WIDTH=8, MAX_WORDS=4), with a
//   second instance in odd-parity mode.
// -----------------------------------------------------------------------------
module tb_xor_stream_parity;

   localparam int W  = 8;
   localparam int MW = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_last, out_ready;
   logic [W-1:0] in_data;
   logic         in_ready, out_valid, out_par, out_err;
   logic [W-1:0] out_col;
   logic [2:0]   out_count;

   logic         o_in_valid, o_in_last, o_out_ready;
   logic [W-1:0] o_in_data;
   logic         o_in_ready, o_out_valid, o_out_par, o_out_err;
   logic [W-1:0] o_out_col;
   logic [2:0]   o_out_count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   xor_stream_parity #(.WIDTH(W), .MAX_WORDS(MW), .ODD_PARITY(0)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
      .out_ready(out_ready), .out_col(out_col), .out_par(out_par),
      .out_count(out_count), .out_err(out_err));

   xor_stream_parity #(.WIDTH(W), .MAX_WORDS(MW), .ODD_PARITY(1)) u_dut_odd (
      .clk(clk), .rst(rst), .in_valid(o_in_valid), .in_ready(o_in_ready),
      .in_data(o_in_data), .in_last(o_in_last), .out_valid(o_out_valid),
      .out_ready(o_out_ready), .out_col(o_out_col), .out_par(o_out_par),
      .out_count(o_out_count), .out_err(o_out_err));

   typedef struct {
      logic [47:0] words;   // word j in bits [8j +: 8]
      int          n;
      int          gap;     // idle cycles before each word
      logic [7:0]  col;
      logic        par;
      logic [2:0]  cnt;
      logic        err;
   } vec_t;

   vec_t tbl[8];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   // Present one word and hold it until accepted (bounded wait).
   task automatic send(input logic [7:0] d, input logic l, input int gap);
      int k;
      in_valid = 1'b0;
      repeat (gap) step();
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      k = 0;
      while (!in_ready && k < 50) begin
         step();
         k++;
      end
      if (k >= 50) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", k);
      end
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic handoff(input string nm);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk({nm, "_valid_drop"}, out_valid, 0);
      chk({nm, "_ready_back"}, in_ready, 1);
   endtask

   // Reference: result of a complete frame, from the list of accepted words.
   task automatic ref_frame(input logic [7:0] q[$], input logic odd,
                            output logic [7:0] col, output logic par,
                            output logic [2:0] cnt, output logic err);
      col = 8'h00;
      foreach (q[i]) col = col ^ q[i];
      par = (^col) ^ odd;
      cnt = (q.size() > MW) ? 3'(MW) : 3'(q.size());
      err = (q.size() > MW);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] q[$];
      logic [7:0] e_col;
      logic       e_par, e_err;
      logic [2:0] e_cnt;
      logic       m_hold;

      // Table: {words, n, gap, col, par, cnt, err}
      tbl[0] = '{48'h0000_00FF_F00F, 3, 0, 8'h00, 1'b0, 3'd3, 1'b0};
      tbl[1] = '{48'h0000_00FF_F00F, 3, 2, 8'h00, 1'b0, 3'd3, 1'b0};
      tbl[2] = '{48'h0000_0000_0081, 1, 0, 8'h81, 1'b0, 3'd1, 1'b0};
      tbl[3] = '{48'h0101_0101_0101, 6, 0, 8'h00, 1'b0, 3'd4, 1'b1};
      tbl[4] = '{48'h0000_0000_0002, 1, 0, 8'h02, 1'b1, 3'd1, 1'b0};
      tbl[5] = '{48'h0000_8844_2211, 4, 0, 8'hFF, 1'b0, 3'd4, 1'b0};
      tbl[6] = '{48'h0001_0101_0101, 5, 1, 8'h01, 1'b1, 3'd4, 1'b1};
      tbl[7] = '{48'h0000_0000_5AA5, 2, 3, 8'hFF, 1'b0, 3'd2, 1'b0};

      rst = 1'b1;
      in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
      o_in_valid = 1'b0; o_in_last = 1'b0; o_in_data = '0; o_out_ready = 1'b0;

      // ---- reset
      step();
      step();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_col",   out_col,   8'h00);
      chk("rst_out_par",   out_par,   0);
      chk("rst_out_count", out_count, 0);
      chk("rst_out_err",   out_err,   0);
      chk("rst_odd_par",   o_out_par, 1);
      rst = 1'b0;
      step();
      chk("rst_in_ready",  in_ready,  1);

      // ---- table-driven frames
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < tbl[i].n; j++) begin
            logic [47:0] w;
            w = tbl[i].words;
            send(w[8*j +: 8], (j == tbl[i].n - 1), tbl[i].gap);
         end
         chk($sformatf("tbl%0d_valid", i), out_valid, 1);
         chk($sformatf("tbl%0d_in_ready", i), in_ready, 0);
         chk($sformatf("tbl%0d_col", i), out_col, tbl[i].col);
         chk($sformatf("tbl%0d_par", i), out_par, tbl[i].par);
         chk($sformatf("tbl%0d_cnt", i), out_count, tbl[i].cnt);
         chk($sformatf("tbl%0d_err", i), out_err, tbl[i].err);
         handoff($sformatf("tbl%0d", i));
         chk($sformatf("tbl%0d_col_kept", i), out_col, tbl[i].col);
      end

      // ---- backpressure with a source holding 0x55
      send(8'h81, 1'b1, 0);
      in_valid = 1'b1; in_data = 8'h55; in_last = 1'b0;
      for (int c = 0; c < 5; c++) begin
         step();
         chk("bp_valid",    out_valid, 1);
         chk("bp_in_ready", in_ready,  0);
         chk("bp_col",      out_col,   8'h81);
         chk("bp_par",      out_par,   0);
         chk("bp_cnt",      out_count, 1);
      end
      handoff("bp");
      step();                     // 0x55 accepted on this edge
      send(8'h0F, 1'b1, 0);
      chk("bp_next_col", out_col,   8'h5A);
      chk("bp_next_cnt", out_count, 2);
      handoff("bp_next");

      // ---- mid-frame reset
      send(8'h11, 1'b0, 0);
      send(8'h22, 1'b0, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      send(8'h3C, 1'b1, 0);
      chk("mfr_col", out_col,   8'h3C);
      chk("mfr_cnt", out_count, 1);
      chk("mfr_err", out_err,   0);

      // ---- reset while holding a result
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("hr_valid",    out_valid, 0);
      chk("hr_col",      out_col,   8'h00);
      chk("hr_in_ready", in_ready,  1);

      // ---- out_ready with nothing held has no effect
      out_ready = 1'b1;
      step();
      step();
      out_ready = 1'b0;
      chk("idle_ready_valid", out_valid, 0);
      send(8'h07, 1'b1, 0);
      chk("idle_ready_col", out_col, 8'h07);
      chk("idle_ready_par", out_par, 1);
      handoff("idle_ready");

      // ---- odd parity instance, single word
      chk("odd_in_ready", o_in_ready, 1);
      o_in_valid = 1'b1; o_in_data = 8'hA5; o_in_last = 1'b1;
      step();
      o_in_valid = 1'b0; o_in_last = 1'b0;
      chk("odd_valid", o_out_valid, 1);
      chk("odd_col",   o_out_col,   8'hA5);
      chk("odd_par",   o_out_par,   1);
      chk("odd_cnt",   o_out_count, 1);
      chk("odd_err",   o_out_err,   0);
      o_out_ready = 1'b1;
      step();
      o_out_ready = 1'b0;
      chk("odd_drop",  o_out_valid, 0);

      // ---- randomized traffic against the frame-level reference
      m_hold = 1'b0;
      q.delete();
      e_col = '0; e_par = 1'b0; e_cnt = '0; e_err = 1'b0;
      for (int c = 0; c < 1500; c++) begin
         in_valid  = ($urandom % 3) != 0;
         in_data   = 8'($urandom);
         in_last   = ($urandom % 5) == 0;
         out_ready = ($urandom % 3) == 0;
         if (!m_hold) begin
            if (in_valid) begin
               q.push_back(in_data);
               if (in_last) begin
                  ref_frame(q, 1'b0, e_col, e_par, e_cnt, e_err);
                  q.delete();
                  m_hold = 1'b1;
               end
            end
         end else if (out_ready) begin
            m_hold = 1'b0;
         end
         step();
         chk("rnd_valid",    out_valid, m_hold);
         chk("rnd_in_ready", in_ready,  !m_hold);
         if (m_hold) begin
            chk("rnd_col", out_col,   e_col);
            chk("rnd_par", out_par,   e_par);
            chk("rnd_cnt", out_count, e_cnt);
            chk("rnd_err", out_err,   e_err);
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
